// File: rtl/hex_display_mux.sv
// rtl/hex_display_mux.sv - multiplexed common-anode hex display driver with PWM brightness
// Optional leading-zero blanking is compiled in with HEX_DISPLAY_MUX_LZB_EN.
module hex_display_mux #(
    parameter int DIGITS     = 4,
    parameter int PRESCALE_W = 12,
    parameter int BRIGHT_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic [BRIGHT_W-1:0]   brightness,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     anodes,
    output logic [6:0]            segments,
    output logic                  dp_out,
    output logic [2:0]            digit_idx
);

    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [2:0]            idx_q, idx_d;
    logic [4*DIGITS-1:0]   data_q, data_d;
    logic [DIGITS-1:0]     dp_q, dp_d;
    logic [DIGITS-1:0]     anodes_q, anodes_d;
    logic [6:0]            segments_q, segments_d;
    logic                  dp_out_q, dp_out_d;

    logic                  tick;
    logic                  pwm_on;
    logic                  blank;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic [DIGITS-1:0]     cur_onehot;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h7E;
            4'h1: seg = 7'h30;
            4'h2: seg = 7'h6D;
            4'h3: seg = 7'h79;
            4'h4: seg = 7'h33;
            4'h5: seg = 7'h5B;
            4'h6: seg = 7'h5F;
            4'h7: seg = 7'h70;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h7B;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h1F;
            4'hC: seg = 7'h4E;
            4'hD: seg = 7'h3D;
            4'hE: seg = 7'h4F;
            default: seg = 7'h47;
        endcase
        return seg;
    endfunction

    assign tick   = &prescale_q;
    assign pwm_on = (&brightness) ||
                    (prescale_q[PRESCALE_W-1 -: BRIGHT_W] < brightness);

    always_comb begin
        cur_nib    = 4'd0;
        cur_dp     = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                cur_nib       = data_q[4*i +: 4];
                cur_dp        = dp_q[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

`ifdef HEX_DISPLAY_MUX_LZB_EN
    // Blank the current digit when it and every more-significant nibble are zero.
    always_comb begin
        blank = blank_lz && (idx_q != 3'd0);
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(idx_q) && data_q[4*i +: 4] != 4'd0) begin
                blank = 1'b0;
            end
        end
    end
`else
    logic unused_blank_lz;
    assign unused_blank_lz = blank_lz;
    assign blank           = 1'b0;
`endif

    always_comb begin
        prescale_d = prescale_q + PRESCALE_W'(1);
        idx_d      = idx_q;
        if (tick) begin
            idx_d = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end
        data_d     = load ? data : data_q;
        dp_d       = load ? dp : dp_q;
        anodes_d   = '0;
        segments_d = 7'd0;
        dp_out_d   = 1'b0;
        if (pwm_on && !blank) begin
            anodes_d   = cur_onehot;
            segments_d = hex_to_seg(cur_nib);
            dp_out_d   = cur_dp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_q <= '0;
            idx_q      <= 3'd0;
            data_q     <= '0;
            dp_q       <= '0;
            anodes_q   <= '0;
            segments_q <= 7'd0;
            dp_out_q   <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            dp_q       <= dp_d;
            anodes_q   <= anodes_d;
            segments_q <= segments_d;
            dp_out_q   <= dp_out_d;
        end
    end

    assign anodes    = anodes_q;
    assign segments  = segments_q;
    assign dp_out    = dp_out_q;
    assign digit_idx = idx_q;

endmodule

// File: doc/hex_display_mux.md
# hex_display_mux

Parametrised multiplexed hex display driver for common-anode 7-segment modules, the successor to the fixed 4-digit driver. Contains its own refresh prescaler, a data shadow register with a load strobe, per-digit decimal points, PWM brightness control and optional leading-zero blanking. Sits between a data source (counter, register file) and the board's digit-enable and segment pins; the top level applies pin polarity inversion.

## Interface
- DIGITS, 4: number of multiplexed digits, 1..8; digit 0 is least significant.
- PRESCALE_W, 12: refresh prescaler width; each digit is lit for 2^PRESCALE_W clocks.
- BRIGHT_W, 4: brightness control width; must satisfy BRIGHT_W <= PRESCALE_W.

- clk  in  1  system clock; one clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data  in  4*DIGITS  hex nibbles; nibble i = data[4i+3:4i] drives digit i.
- dp  in  DIGITS  decimal-point request per digit.
- load  in  1  when 1 at a clock edge, data and dp are captured into the shadow registers.
- brightness  in  BRIGHT_W  duty control; 0 = dark, all-ones = fully on.
- blank_lz  in  1  leading-zero blanking enable (used only with HEX_DISPLAY_MUX_LZB_EN).
- anodes  out  DIGITS  one-hot digit enable, active-high, registered.
- segments  out  7  {a,b,c,d,e,f,g}, active-high, registered.
- dp_out  out  1  decimal-point segment, active-high, registered.
- digit_idx  out  3  index of the digit currently being scanned.

## Operation
- Shadow: data_q/dp_q load on load=1; otherwise hold. Display uses shadow only.
- Prescaler: PRESCALE_W-bit free-running counter. Tick when counter is all-ones.
- Scan index: advances 0,1,...,DIGITS-1,0 on each tick; wraps at DIGITS-1, never reaches DIGITS..7. DIGITS=1: index stays 0.
- Decoder: nibble -> {a..g}: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47.
- PWM: digit lit when brightness is all-ones, or when prescaler[PRESCALE_W-1 -: BRIGHT_W] < brightness. brightness=0 -> anodes always 0.
- Blanking (when compiled in and blank_lz=1): digit i>0 blanked if nibbles i..DIGITS-1 are all zero; digit 0 never blanked. dp request on a blanked digit is suppressed.
- Dark/blanked digit: anodes=0, segments=0, dp_out=0. Lit digit: anodes = one-hot(index), segments = decode(nibble), dp_out = dp_q[index].

## Timing
- Reset: prescaler=0, index=0, shadow=0, anodes=0, segments=0, dp_out=0, digit_idx=0.
- Output registers sample index, prescaler and shadow each cycle: 1-cycle latency.
- Index changes on the edge after the prescaler reaches all-ones; anodes follow one cycle later, so anodes never show two bits set.
- Shadow load at edge N -> visible on segments at edge N+1 if that digit is scanned and lit.
- load asserted continuously: shadow tracks inputs every cycle.
- Brightness change takes effect at the next clock; no resynchronisation to scan boundary.
- rst mid-scan: all state cleared immediately (asynchronous), scan restarts at digit 0.

## Configuration
- HEX_DISPLAY_MUX_LZB_EN defined: leading-zero blanking logic present, controlled by blank_lz.
- Not defined: blanking logic removed; blank_lz ignored; every digit shows its nibble including leading zeros.

## Test plan
- Reset: DIGITS=4, PRESCALE_W=4; assert rst mid-scan -> all outputs 0 asynchronously; after release digit_idx=0, first tick after 16 clocks.
- Scan/decode: load data=16'h3A7F, brightness=F -> anodes cycle 0001,0010,0100,1000 every 16 clocks; segments F=47, 7=70, A=77, 3=79; digit_idx wraps 3->0.
- Load hold: load data=16'h1234 then drive data=16'hFFFF with load=0 -> display keeps 1234; pulse load -> FFFF appears 1 cycle later on the active digit.
- PWM: BRIGHT_W=4, brightness=4 -> active anode high 4 of every 16 clocks; brightness=0 -> anodes stay 0; brightness=F -> high all 16.
- Blanking (macro defined): data=16'h0050, blank_lz=1, dp=4'b1000 -> digits 3,2 dark, dp_out never 1; digits 1,0 show 5,0; data=16'h0000 -> only digit 0 lit showing 0 (7E). Macro undefined: all four digits lit.
- DIGITS=1 and DIGITS=8 builds: index stays 0 / wraps 7->0; anodes width matches.
